// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the B32P memory access path: FSM state encoding
// common to the load/store unit and the future instruction-fetch unit.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_unit_timeout_counter.sv
// BUSY-cycle counter with terminal-count flag at TIMEOUT_CYC-1.
// TIMEOUT_CYC of 0 disables the flag entirely.
module timeout_counter #(
  parameter int CNT_W       = 11,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (TIMEOUT_CYC != 0) && (count == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// Variable-latency load/store unit for the B32P MEM stage: issues one
// request on a start/done bus and stalls the pipeline until it completes.
//
//  state  | meaning
//  IDLE   | waiting for cpu_req; accepts and latches the request
//  BUSY   | bus transaction outstanding; waits for bus_done or timeout
//  DONE   | result presented, pipeline released for one cycle
module mem_access_unit #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT_CYC = 1024,
  parameter int                CNT_W       = 11,
  parameter logic [DATA_W-1:0] ERR_DATA    = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              err,
  output logic              bus_start,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_done
);

  import mem_access_unit_pkg::*;

  state_t state, state_nxt;
  logic   accept, capture, abort, tc;

  timeout_counter #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state != S_BUSY),
    .enable(state == S_BUSY),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cpu_req) state_nxt = S_BUSY;
      S_BUSY:  if (bus_done || tc) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A done arriving on the terminal-count cycle takes priority over the abort.
  always_comb begin
    accept  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    stall   = 1'b0;
    case (state)
      S_IDLE: begin
        accept = cpu_req;
        stall  = cpu_req;
      end
      S_BUSY: begin
        stall   = 1'b1;
        capture = bus_done;
        abort   = tc && !bus_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_start <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      err       <= 1'b0;
    end else begin
      bus_start <= accept;
      err       <= abort;
      if (accept) begin
        bus_we    <= cpu_we;
        bus_addr  <= cpu_addr;
        bus_wdata <= cpu_wdata;
      end
      if (capture) begin
        cpu_rdata <= bus_we ? '0 : bus_rdata;
      end else if (abort) begin
        cpu_rdata <= ERR_DATA;
      end
    end
  end

endmodule
